rc4_key_dispatcher: RTL and testbench
=====================================

Name: rc4_key_dispatcher

Overview:
- N-core key-search scheduler for the RC4 brute-force datapath.
- Replaces per-core fixed-stride key counters with one shared key counter over a runtime range [key_lo, key_hi].
- Issues each key exactly once to whichever init/shuffle/decrypt core chain is free, collects done/valid results, aborts all cores on the first hit and reports the key and core index.
- Sits between the top level (switches, HEX display, LEDs) and NUM_CORES RC4 core chains.

Parameters:
NUM_CORES, 2, number of RC4 core chains served (1..16)
KEY_WIDTH, 22, width of the searched key value; the core is fed {2'b0, key}
IDX_WIDTH, $clog2(NUM_CORES) (min 1), width of the core index fields

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; samples key_lo and key_hi and begins a search
key_lo  in  KEY_WIDTH  first key of the range (inclusive)
key_hi  in  KEY_WIDTH  last key of the range (inclusive)
core_start  out  NUM_CORES  per-core one-cycle launch pulse (drives the core's init FSM start)
core_key  out  NUM_CORES*KEY_WIDTH  per-core key, held stable while that core is busy
core_abort  out  NUM_CORES  per-core one-cycle abort pulse (drives the core reset)
core_done  in  NUM_CORES  per-core one-cycle completion pulse (decrypt finish)
core_valid  in  NUM_CORES  per-core result qualifier, sampled with core_done
busy  out  1  search in progress
found  out  1  sticky; a valid key was found
exhausted  out  1  sticky; range completed with no hit
found_key  out  KEY_WIDTH  key that produced the hit
found_core  out  IDX_WIDTH  index of the core that reported the hit
keys_tried  out  KEY_WIDTH+1  number of completed keys in this search (for HEX display)

Behaviour:
- Reset: state IDLE. All outputs 0. All core slots free. next_key = 0. issued_all = 0.
- States: IDLE, RUN, FOUND, EXHAUSTED. All outputs are registered.
- Entering a search (start while in IDLE, FOUND or EXHAUSTED):
  - Latch next_key = key_lo and hi_reg = key_hi.
  - Clear found, exhausted, keys_tried and found_key/found_core.
  - Clear issued_all, free all slots, go to RUN.
  - If key_lo > key_hi, set issued_all at the same time.
- start while in RUN is ignored.
- Dispatch (RUN only):
  - At most one dispatch per cycle, to the lowest-index free slot, and only while issued_all = 0.
  - A dispatch sets core_key[i] = next_key, pulses core_start[i] for one cycle and marks slot i busy.
  - If next_key == hi_reg, set issued_all; otherwise increment next_key.
  - next_key never wraps, including when hi_reg is all-ones.
- Latency: start sampled at edge E0 gives core_start[0] high from E1 to E2, core_start[1] from E2 to E3, and so on.
- Completion:
  - core_done[i] while slot i is busy frees the slot and increments keys_tried.
  - core_done on a free slot is ignored and not counted.
  - A slot freed in cycle t is dispatchable at the earliest in cycle t+1.
  - core_valid is ignored unless core_done is high in the same cycle.
- Hit:
  - Any core_done[i] & core_valid[i] on a busy slot selects the lowest such i.
  - On the next edge: found = 1, found_key = core_key[i], found_core = i, and the state goes to FOUND.
  - core_abort is pulsed for one cycle on every slot that is still busy, excluding i; all slots become free.
  - No dispatch happens in that cycle.
- Completion and dispatch in the same cycle: the hit takes priority and the dispatch is suppressed.
- FOUND / EXHAUSTED: no dispatch. core_done/core_valid are ignored. Outputs hold until the next start or rst.
- Exhaustion: in RUN with issued_all = 1, no slot busy and no hit this cycle, go to EXHAUSTED with exhausted = 1.
- busy = 1 exactly in RUN.
- rst mid-search: immediate return to the reset state. No abort pulse; the core chains share rst.

Decomposition:
- Package rc4_pkg holds:
  - the dispatcher state enum (IDLE, RUN, FOUND, EXHAUSTED);
  - the KEY_WIDTH default (22);
  - the RC4 secret key width constant (24);
  - the function mapping a search key to the core key, {2'b0, key}.
- One sub-module: rc4_prio_enc, a parametrised lowest-set-bit encoder producing index and any flag. It is instantiated twice: once for the free-slot vector and once for the hit vector.

Test Plan:
- NUM_CORES=2, key_lo=0, key_hi=5, cores model done after 10 cycles with valid=0 → keys 0..5 each issued once (core 0: 0,2,4; core 1: 1,3,5); exhausted=1; keys_tried=6; found=0.
- Same range, core returning key 3 reports valid → found=1, found_key=3, found_core=1; core_abort pulses on the other busy core; no core_start after the hit.
- Both cores report done & valid in the same cycle with keys 4 and 5 → found_core=0, found_key=4.
- key_lo=key_hi=22'h3FFFFF → exactly one dispatch; no wrap to 0; exhausted after its done; keys_tried=1.
- key_lo=10, key_hi=9 → no core_start; exhausted=1 two cycles after start.
- rst asserted mid-RUN with 2 busy slots → all outputs 0 asynchronously. A spurious core_done after release is ignored (keys_tried stays 0). A new start with key_lo=7 issues key 7 to core 0.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 key-search dispatcher and its core chains.
package rc4_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        FOUND     = 2'd2,
        EXHAUSTED = 2'd3
    } disp_state_e;

    localparam int DEFAULT_KEY_WIDTH = 22;
    localparam int SECRET_KEY_WIDTH  = 24;

    // The RC4 cores take a 24-bit secret; the searched space is its low 22 bits.
    function automatic logic [SECRET_KEY_WIDTH-1:0] to_core_key(
        input logic [DEFAULT_KEY_WIDTH-1:0] key
    );
        return {{(SECRET_KEY_WIDTH-DEFAULT_KEY_WIDTH){1'b0}}, key};
    endfunction

endpackage

// File: rtl/rc4_prio_enc.sv
// Lowest-set-bit priority encoder: index of the lowest asserted request plus an any flag.
module rc4_prio_enc #(
    parameter int WIDTH     = 2,
    parameter int IDX_WIDTH = 1
) (
    input  logic [WIDTH-1:0]     req,
    output logic [IDX_WIDTH-1:0] idx,
    output logic                 any
);

    always_comb begin
        // NOTE: every output gets a default first so no path through the loop infers a latch.
        idx = '0;
        any = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_WIDTH'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rc4_key_dispatcher.sv
// Shared key counter that hands each key of [key_lo, key_hi] to the first free RC4 core
// chain, collects results, and aborts the remaining chains on the first hit.
module rc4_key_dispatcher
    import rc4_pkg::*;
#(
    parameter int NUM_CORES = 2,
    parameter int KEY_WIDTH = DEFAULT_KEY_WIDTH,
    parameter int IDX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [KEY_WIDTH-1:0]           key_lo,
    input  logic [KEY_WIDTH-1:0]           key_hi,
    output logic [NUM_CORES-1:0]           core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
    output logic [NUM_CORES-1:0]           core_abort,
    input  logic [NUM_CORES-1:0]           core_done,
    input  logic [NUM_CORES-1:0]           core_valid,
    output logic                           busy,
    output logic                           found,
    output logic                           exhausted,
    output logic [KEY_WIDTH-1:0]           found_key,
    output logic [IDX_WIDTH-1:0]           found_core,
    output logic [KEY_WIDTH:0]             keys_tried
);

    localparam logic [1:0] S_IDLE      = IDLE;
    localparam logic [1:0] S_RUN       = RUN;
    localparam logic [1:0] S_FOUND     = FOUND;
    localparam logic [1:0] S_EXHAUSTED = EXHAUSTED;

    logic [1:0]           state;
    logic [KEY_WIDTH-1:0] next_key;
    logic [KEY_WIDTH-1:0] hi_reg;
    logic                 issued_all;
    logic [NUM_CORES-1:0] slot_busy;

    logic                 in_run;
    logic [NUM_CORES-1:0] done_busy;
    logic [NUM_CORES-1:0] hit_vec;
    logic [NUM_CORES-1:0] free_onehot;
    logic [NUM_CORES-1:0] hit_onehot;
    logic [IDX_WIDTH-1:0] free_idx;
    logic [IDX_WIDTH-1:0] hit_idx;
    logic                 free_any;
    logic                 hit_any;
    logic                 dispatch;
    logic [KEY_WIDTH:0]   done_count;
    logic [KEY_WIDTH-1:0] hit_key;

    assign in_run      = (state == S_RUN);
    assign done_busy   = in_run ? (core_done & slot_busy) : '0;
    assign hit_vec     = done_busy & core_valid;
    assign free_onehot = NUM_CORES'(1) << free_idx;
    assign hit_onehot  = NUM_CORES'(1) << hit_idx;
    assign done_count  = (KEY_WIDTH+1)'($countones(done_busy));
    // A slot freed this cycle still reads busy here, so it is reusable next cycle at the earliest.
    assign dispatch    = in_run && !issued_all && free_any && !hit_any;

    rc4_prio_enc #(.WIDTH(NUM_CORES), .IDX_WIDTH(IDX_WIDTH)) u_free_enc (
        .req (~slot_busy),
        .idx (free_idx),
        .any (free_any)
    );

    rc4_prio_enc #(.WIDTH(NUM_CORES), .IDX_WIDTH(IDX_WIDTH)) u_hit_enc (
        .req (hit_vec),
        .idx (hit_idx),
        .any (hit_any)
    );

    always_comb begin
        hit_key = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (hit_idx == IDX_WIDTH'(i)) hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            next_key   <= '0;
            hi_reg     <= '0;
            issued_all <= 1'b0;
            slot_busy  <= '0;
            core_start <= '0;
            // NOTE: the per-core key registers are plain flops driving outputs, so they are reset too.
            core_key   <= '0;
            core_abort <= '0;
            busy       <= 1'b0;
            found      <= 1'b0;
            exhausted  <= 1'b0;
            found_key  <= '0;
            found_core <= '0;
            keys_tried <= '0;
        end else begin
            // NOTE: non-blocking throughout; a later assignment in the same edge overrides these defaults.
            core_start <= '0;
            core_abort <= '0;
            if (in_run) begin
                slot_busy  <= slot_busy & ~done_busy;
                keys_tried <= keys_tried + done_count;
                if (hit_any) begin
                    state      <= S_FOUND;
                    busy       <= 1'b0;
                    found      <= 1'b1;
                    found_key  <= hit_key;
                    found_core <= hit_idx;
                    core_abort <= slot_busy & ~hit_onehot;
                    slot_busy  <= '0;
                end else if (issued_all && slot_busy == '0) begin
                    state     <= S_EXHAUSTED;
                    busy      <= 1'b0;
                    exhausted <= 1'b1;
                end else if (dispatch) begin
                    core_start <= free_onehot;
                    slot_busy  <= (slot_busy & ~done_busy) | free_onehot;
                    for (int i = 0; i < NUM_CORES; i++) begin
                        if (free_idx == IDX_WIDTH'(i)) core_key[i*KEY_WIDTH +: KEY_WIDTH] <= next_key;
                    end
                    // Stop at hi_reg instead of incrementing so the counter never wraps.
                    if (next_key == hi_reg) issued_all <= 1'b1;
                    else                    next_key   <= next_key + 1'b1;
                end
            end else if (start) begin
                state      <= S_RUN;
                busy       <= 1'b1;
                next_key   <= key_lo;
                hi_reg     <= key_hi;
                issued_all <= (key_lo > key_hi);
                slot_busy  <= '0;
                found      <= 1'b0;
                exhausted  <= 1'b0;
                found_key  <= '0;
                found_core <= '0;
                keys_tried <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rc4_key_dispatcher.sv
// Self-checking bench: table and random searches against a cycle-level schedule model.
module tb_rc4_key_dispatcher;

    localparam int NC   = 2;
    localparam int KW   = 22;
    localparam int IW   = 1;
    localparam int KMAX = (1 << KW) - 1;
    localparam int NOHIT = 1 << 30;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [KW-1:0]  key_lo, key_hi;
    logic [NC-1:0]  core_start, core_abort, core_done, core_valid;
    logic [NC*KW-1:0] core_key;
    logic           busy, found, exhausted;
    logic [KW-1:0]  found_key;
    logic [IW-1:0]  found_core;
    logic [KW:0]    keys_tried;

    always #5 clk = ~clk;

    rc4_key_dispatcher #(.NUM_CORES(NC), .KEY_WIDTH(KW)) dut (
        .clk(clk), .rst(rst), .start(start), .key_lo(key_lo), .key_hi(key_hi),
        .core_start(core_start), .core_key(core_key), .core_abort(core_abort),
        .core_done(core_done), .core_valid(core_valid),
        .busy(busy), .found(found), .exhausted(exhausted),
        .found_key(found_key), .found_core(found_core), .keys_tried(keys_tried)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Target range tgt_lo..tgt_hi marks keys the cores report as valid (empty when lo > hi).
    // exp_* fields of -1 are not checked against the table.
    typedef struct {
        int lo, hi, lat0, lat1, tgt_lo, tgt_hi, ign;
        bit junk;
        int exp_found, exp_key, exp_core, exp_tried;
    } vec_t;

    task automatic run_search(input vec_t v, input string tag);
        int lat[NC];
        int ms[$], mc[$], mk[$];
        int on[$], oc[$], ok[$];
        int avail[NC];
        int pn[NC], pk[NC];
        bit pend[NC];
        int h, hc, hk, dmax, t, c, exp_end, end_n;
        bit hit, busy_low;
        logic [NC-1:0] exp_abort, abort_acc;

        lat[0] = v.lat0; lat[1] = v.lat1;
        for (int j = 0; j < NC; j++) begin avail[j] = 0; pend[j] = 0; pn[j] = 0; pk[j] = 0; end
        h = NOHIT; hc = 0; hk = 0; dmax = -1; t = 1; exp_abort = '0;

        // Schedule model: key k starts on the lowest core free at cycle t, finishes at
        // t+lat, and that core can start again at t+lat+2. Nothing starts after the hit cycle.
        if (v.lo <= v.hi) begin
            for (longint k = v.lo; k <= v.hi; k++) begin
                c = -1;
                while (c < 0) begin
                    for (int j = 0; j < NC; j++) if (c < 0 && avail[j] <= t) c = j;
                    if (c < 0) t++;
                end
                if (t > h) break;
                ms.push_back(t); mc.push_back(c); mk.push_back(int'(k));
                avail[c] = t + lat[c] + 2;
                if (t + lat[c] > dmax) dmax = t + lat[c];
                if (k >= v.tgt_lo && k <= v.tgt_hi && (t + lat[c] < h || (t + lat[c] == h && c < hc))) begin
                    h = t + lat[c]; hc = c; hk = int'(k);
                end
                t++;
            end
        end
        hit = (h != NOHIT);
        if (hit) begin
            foreach (ms[i]) if (mc[i] != hc && ms[i] <= h && h <= ms[i] + lat[mc[i]]) exp_abort[mc[i]] = 1'b1;
        end
        exp_end = hit ? h + 1 : dmax + 2;

        @(negedge clk);
        key_lo = KW'(v.lo); key_hi = KW'(v.hi); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        end_n = -1; busy_low = 0; abort_acc = '0;
        for (int n = 0; n < 400; n++) begin
            abort_acc |= core_abort;
            if (found || exhausted) begin end_n = n; break; end
            if (!busy) busy_low = 1;
            for (int j = 0; j < NC; j++) begin
                if (core_start[j]) begin
                    on.push_back(n); oc.push_back(j); ok.push_back(int'(core_key[j*KW +: KW]));
                    pend[j] = 1; pn[j] = n + lat[j]; pk[j] = int'(core_key[j*KW +: KW]);
                end
            end
            for (int j = 0; j < NC; j++) begin
                if (pend[j] && pn[j] == n) begin
                    core_done[j]  = 1'b1;
                    core_valid[j] = (pk[j] >= v.tgt_lo && pk[j] <= v.tgt_hi);
                    pend[j] = 0;
                end else begin
                    core_done[j]  = v.junk && !pend[j] && ($urandom_range(0, 3) == 0);
                    core_valid[j] = 1'($urandom_range(0, 1));
                end
            end
            if (n == v.ign) begin start = 1'b1; key_lo = KW'(50); key_hi = KW'(60); end
            else start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0; core_done = '0; core_valid = '0;
        check({tag, ".end_cycle"}, 64'(end_n), 64'(exp_end));

        @(negedge clk);
        check({tag, ".pulses_cleared"}, {core_start, core_abort}, '0);
        core_done = '1; core_valid = '1;
        @(negedge clk);
        core_done = '0; core_valid = '0;
        @(negedge clk);

        check({tag, ".found"}, found, hit);
        check({tag, ".exhausted"}, exhausted, !hit);
        check({tag, ".busy_after"}, busy, 0);
        check({tag, ".busy_during"}, busy_low, 0);
        check({tag, ".found_key"}, found_key, hit ? hk : 0);
        check({tag, ".found_core"}, found_core, hit ? hc : 0);
        check({tag, ".abort"}, abort_acc, exp_abort);
        if (!hit) check({tag, ".keys_tried"}, keys_tried, mk.size());
        check({tag, ".n_dispatch"}, on.size(), ms.size());
        for (int i = 0; i < on.size() && i < ms.size(); i++)
            check($sformatf("%s.dispatch%0d", tag, i), {16'(on[i]), 8'(oc[i]), 32'(ok[i])},
                  {16'(ms[i]), 8'(mc[i]), 32'(mk[i])});
        if (v.exp_found >= 0) check({tag, ".tbl_found"}, found, v.exp_found);
        if (v.exp_key   >= 0) check({tag, ".tbl_key"}, found_key, v.exp_key);
        if (v.exp_core  >= 0) check({tag, ".tbl_core"}, found_core, v.exp_core);
        if (v.exp_tried >= 0) check({tag, ".tbl_tried"}, keys_tried, v.exp_tried);
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        rst = 1'b1; start = 1'b0; key_lo = '0; key_hi = '0; core_done = '0; core_valid = '0;

        //          lo    hi    l0  l1  tlo   thi   ign junk found key  core tried
        tbl[0] = '{0,    5,    10, 10, 1,    0,    -1, 0,   0,   -1,  -1,  6};
        tbl[1] = '{0,    5,    10, 12, 3,    3,    -1, 0,   1,   3,   1,   -1};
        tbl[2] = '{0,    5,    6,  5,  4,    5,    -1, 0,   1,   4,   0,   -1};
        tbl[3] = '{KMAX, KMAX, 4,  4,  1,    0,    -1, 0,   0,   -1,  -1,  1};
        tbl[4] = '{10,   9,    3,  3,  1,    0,    -1, 0,   0,   -1,  -1,  0};
        tbl[5] = '{0,    3,    3,  3,  1,    0,    3,  0,   0,   -1,  -1,  4};

        #12;
        check("reset.ctrl", {busy, found, exhausted, core_start, core_abort, found_core}, '0);
        check("reset.data", {found_key, keys_tried}, '0);
        check("reset.core_key", core_key, '0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_search(tbl[i], $sformatf("tbl%0d", i));

        for (int i = 0; i < 24; i++) begin
            rv.lo = $urandom_range(0, KMAX);
            if ($urandom_range(0, 3) == 0) rv.lo = KMAX - $urandom_range(0, 5);
            rv.hi = rv.lo + $urandom_range(0, 8);
            if (rv.hi > KMAX) rv.hi = KMAX;
            if ($urandom_range(0, 7) == 0 && rv.lo > 0) rv.hi = rv.lo - 1;
            rv.lat0 = $urandom_range(1, 12);
            rv.lat1 = $urandom_range(1, 12);
            if ($urandom_range(0, 2) == 0) begin
                rv.tgt_lo = 1; rv.tgt_hi = 0;
            end else begin
                rv.tgt_lo = rv.lo + $urandom_range(0, 8);
                rv.tgt_hi = rv.tgt_lo + $urandom_range(0, 2);
            end
            rv.ign = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 5) : -1;
            rv.junk = 1'b1;
            rv.exp_found = -1; rv.exp_key = -1; rv.exp_core = -1; rv.exp_tried = -1;
            run_search(rv, $sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a search with both slots busy.
        @(negedge clk);
        key_lo = '0; key_hi = KW'(9); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid.busy_before", busy, 1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.ctrl", {busy, found, exhausted, core_start, core_abort, found_core}, '0);
        check("rst_mid.data", {found_key, keys_tried}, '0);
        check("rst_mid.core_key", core_key, '0);
        @(negedge clk);
        rst = 1'b0; core_done = '1; core_valid = '1;
        @(negedge clk);
        core_done = '0; core_valid = '0;
        @(negedge clk);
        check("rst_mid.spurious_done", {busy, found, exhausted, keys_tried}, '0);
        key_lo = KW'(7); key_hi = KW'(7); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid.restart_start", core_start, 2'b01);
        check("rst_mid.restart_key", core_key[KW-1:0], 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
